// File: rtl/pll_lock_sequencer.sv
// Purpose : PLL reset pulse / lock qualification / downstream reset release sequencer with retry and sticky fault.
// Latency : outputs registered from next state; lock edges seen 2 cycles late (synchronizer), +1 edge to act.
// Backpr. : none; relock_req is a single-cycle request, honoured only in RUN and FAULT.
//
// Ports: refclk (sole clock), rst (async active-high), pll_locked (async, synchronized internally),
//        relock_req, pll_rst, sys_rst, ready, fault, retry_cnt[7:0];
//        lock_loss_cnt[7:0] only when PLL_LOCK_SEQ_LOSS_CNT_EN is defined.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_cnt
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  // One shared counter, wide enough for the longest window.
  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW     = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      retry_q, retry_d;
  logic            lock_meta_q, lock_s_q;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_q, sys_rst_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == CW'(RST_PULSE_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a timeout landing in the same cycle.
        if (lock_s_q) begin
          state_d = ST_STABILIZE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (retry_q == 8'(MAX_RETRIES)) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = ST_RESET_PLL;
          end
        end
      end
      ST_STABILIZE: begin
        // A lock dropout restarts qualification without costing a retry.
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          retry_d = 8'd0;
        end
      end
      ST_RUN: begin
        if (!lock_s_q || relock_req) state_d = ST_RESET_PLL;
      end
      ST_FAULT: begin
        if (relock_req) begin
          state_d = ST_RESET_PLL;
          retry_d = 8'd0;
        end
      end
      default: state_d = ST_RESET_PLL;
    endcase

    // Counter restarts on every state change; it only runs in the timed states,
    // each of which leaves before the counter can exceed its own limit.
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == ST_RESET_PLL || state_q == ST_WAIT_LOCK || state_q == ST_STABILIZE)) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Moore outputs decoded from the next state so they switch with the state register.
    pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  // Counts RUN exits where the lock was lost (including when relock_req
  // coincides); a pure relock request is not a loss. Survives relock_req.
  logic [7:0] loss_q, loss_d;
  logic       loss_evt;

  assign loss_evt = (state_q == ST_RUN) && !lock_s_q;

  always_comb begin
    loss_d = loss_q;
    if (loss_evt && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) loss_q <= 8'd0;
    else     loss_q <= loss_d;
  end

  assign lock_loss_cnt = loss_q;
`else
  // Loss counter not built: lock-loss exits are visible only through sys_rst/ready.
`endif

endmodule
